// File: rtl/apb_pkg.sv
// Shared types for the APB master bridge: FSM state encoding and the
// read-data pattern returned when the slave never answers.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SETUP   = 2'b01,
        ACCESS  = 2'b10,
        RD_WAIT = 2'b11
    } apb_state_e;

    localparam logic [31:0] APB_ERR_DATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/apb_master_bridge_fifo.sv
// Request queue between the core and the APB FSM; no bypass, a push into an
// empty queue is visible on the following cycle. Pushes while full are dropped.
module apb_req_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (cnt_q == (PTR_W+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/apb_master_bridge.sv
// Core load/store to APB bridge: queued requests become SETUP/ACCESS transfers;
// reads wait for the slave's valid pulse or time out with an error response.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 2,
    parameter int TIMEOUT    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic              resp_we,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic              valid,
    input  logic [DATA_W-1:0] prdata
);

    localparam int REQ_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    apb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              xfer_we_q, xfer_we_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_we_q, resp_we_d;
    logic              resp_err_q, resp_err_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [REQ_W-1:0]  fifo_din;
    logic [REQ_W-1:0]  fifo_dout;
    logic              head_we;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_wdata;

    assign req_ready = !fifo_full;
    assign fifo_push = req_valid && !fifo_full;
    assign fifo_din  = {req_we, req_addr, req_wdata};
    assign {head_we, head_addr, head_wdata} = fifo_dout;

    apb_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (REQ_W)
    ) u_req_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        xfer_we_d    = xfer_we_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        resp_valid_d = 1'b0;
        resp_we_d    = resp_we_q;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;
        fifo_pop     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    xfer_we_d = head_we;
                    paddr_d   = head_addr;
                    pwdata_d  = head_wdata;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (xfer_we_q) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b1;
                    resp_we_d    = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = '0;
                end else begin
                    state_d = RD_WAIT;
                    cnt_d   = '0;
                end
            end
            RD_WAIT: begin
                if (valid) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b1;
                    resp_we_d    = 1'b0;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = prdata;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // The slave has no error signalling; a silent slave is reported as an error read.
                    state_d      = IDLE;
                    resp_valid_d = 1'b1;
                    resp_we_d    = 1'b0;
                    resp_err_d   = 1'b1;
                    resp_rdata_d = {DATA_W{1'b1}};
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // APB controls are decoded from the next state so they are pure flop outputs.
        psel_d    = (state_d == SETUP) || (state_d == ACCESS);
        penable_d = (state_d == ACCESS);
        pwrite_d  = psel_d && xfer_we_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            xfer_we_q    <= 1'b0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_we_q    <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            xfer_we_q    <= xfer_we_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            resp_valid_q <= resp_valid_d;
            resp_we_q    <= resp_we_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign psel       = psel_q;
    assign penable    = penable_q;
    assign pwrite     = pwrite_q;
    assign paddr      = paddr_q;
    assign pwdata     = pwdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_we    = resp_we_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: a 16-word APB slave, a reference memory model
// and a response scoreboard, driven by directed scenarios then random traffic.
module tb_apb_master_bridge;

    typedef struct {
        bit          we;
        logic [31:0] rdata;
        bit          err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic        resp_we;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        valid;
    logic [31:0] prdata;

    int          checks;
    int          errors;
    exp_t        exp_q[$];
    logic [31:0] mdl_mem [16];

    logic [31:0] slave_mem [16];
    logic        mem_init;
    logic        slv_valid;
    logic [31:0] slv_rdata;
    logic        suppress_valid;
    logic        glitch_valid;

    apb_master_bridge #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .FIFO_DEPTH (2),
        .TIMEOUT    (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_we    (resp_we),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .valid      (valid),
        .prdata     (prdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave: writes land at the ACCESS edge, reads answer with a valid pulse one cycle later.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) slave_mem[i] <= 32'h1111_1111 * i;
        end else if (psel && penable && pwrite) begin
            slave_mem[paddr[3:0]] <= pwdata;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            slv_valid <= 1'b0;
            slv_rdata <= '0;
        end else begin
            slv_valid <= psel && penable && !pwrite;
            if (psel && penable && !pwrite) slv_rdata <= slave_mem[paddr[3:0]];
        end
    end

    assign valid  = (slv_valid && !suppress_valid) || glitch_valid;
    assign prdata = glitch_valid ? 32'hBAD0_BAD0 : slv_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Response scoreboard plus APB protocol watch, sampled on the falling edge.
    logic        prev_psel, prev_penable, prev_pwrite;
    logic [31:0] prev_paddr, prev_pwdata;
    always @(negedge clk) begin
        if (rst) begin
            prev_psel    = 1'b0;
            prev_penable = 1'b0;
        end else begin
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got we=%0b rdata=%h err=%0b, expected none", resp_we, resp_rdata, resp_err);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("resp_we", 32'(resp_we), 32'(e.we));
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("resp_err", 32'(resp_err), 32'(e.err));
                end
            end
            if (psel && !penable) chk("setup_after_idle", 32'(prev_psel), 32'd0);
            if (penable) begin
                chk("access_after_setup", {30'd0, prev_psel, prev_penable}, 32'd2);
                chk("access_psel", 32'(psel), 32'd1);
                chk("access_paddr_stable", paddr, prev_paddr);
                chk("access_pwdata_stable", pwdata, prev_pwdata);
                chk("access_pwrite_stable", 32'(pwrite), 32'(prev_pwrite));
            end
            prev_psel    = psel;
            prev_penable = penable;
            prev_pwrite  = pwrite;
            prev_paddr   = paddr;
            prev_pwdata  = pwdata;
        end
    end

    // Called just after a rising edge; returns just after the accepting edge with req_valid still high.
    task automatic send(input bit we, input logic [31:0] a, input logic [31:0] d,
                        input bit expect_resp, input bit timeout);
        int n;
        exp_t e;
        n = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        while (!req_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("req_ready_wait", 32'(req_ready), 32'd1);
        if (expect_resp) begin
            if (we) begin
                mdl_mem[a[3:0]] = d;
                e = '{we: 1'b1, rdata: 32'd0, err: 1'b0};
            end else if (timeout) begin
                e = '{we: 1'b0, rdata: 32'hFFFF_FFFF, err: 1'b1};
            end else begin
                e = '{we: 1'b0, rdata: mdl_mem[a[3:0]], err: 1'b0};
            end
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst            = 1'b0;
        mem_init       = 1'b0;
        req_valid      = 1'b0;
        req_we         = 1'b0;
        req_addr       = '0;
        req_wdata      = '0;
        suppress_valid = 1'b0;
        glitch_valid   = 1'b0;
        for (int i = 0; i < 16; i++) mdl_mem[i] = 32'h1111_1111 * i;

        #2;
        rst      = 1'b1;
        mem_init = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_psel", 32'(psel), 0);
        chk("rst_penable", 32'(penable), 0);
        chk("rst_pwrite", 32'(pwrite), 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_req_ready", 32'(req_ready), 1);
        mem_init = 1'b0;
        rst      = 1'b0;
        @(posedge clk);
        #1;

        // Reset during ACCESS of a write: transfer dropped, no response, slave untouched.
        send(1'b1, 32'd5, 32'hA5A5_0001, 1'b0, 1'b0);
        idle();
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t1_in_access", {30'd0, psel, penable}, 32'd3);
        rst = 1'b1;
        #1;
        chk("t1_psel", 32'(psel), 0);
        chk("t1_penable", 32'(penable), 0);
        chk("t1_paddr", paddr, 0);
        chk("t1_pwdata", pwdata, 0);
        chk("t1_req_ready", 32'(req_ready), 1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            chk("t1_no_resp", 32'(resp_valid), 0);
        end
        chk("t1_slave_mem5", slave_mem[5], mdl_mem[5]);

        // Single write with exact phase timing.
        send(1'b1, 32'd3, 32'h1234_5678, 1'b1, 1'b0);
        idle();
        @(posedge clk); #1;
        chk("t2_setup", {30'd0, psel, penable}, 32'd2);
        @(posedge clk); #1;
        chk("t2_access", {30'd0, psel, penable}, 32'd3);
        @(posedge clk); #1;
        chk("t2_resp_valid", 32'(resp_valid), 1);
        drain("t2_drain");
        chk("t2_slave_mem3", slave_mem[3], 32'h1234_5678);

        // Read back with exact phase timing.
        send(1'b0, 32'd3, 32'd0, 1'b1, 1'b0);
        idle();
        @(posedge clk); #1;
        chk("t3_setup", {30'd0, psel, penable}, 32'd2);
        @(posedge clk); #1;
        chk("t3_access", {30'd0, psel, penable}, 32'd3);
        @(posedge clk); #1;
        chk("t3_rdwait_no_resp", 32'(resp_valid), 0);
        @(posedge clk); #1;
        chk("t3_resp_valid", 32'(resp_valid), 1);
        drain("t3_drain");

        // Three back-to-back requests fill the 2-deep queue.
        send(1'b1, 32'd7, 32'hDEAD_BEEF, 1'b1, 1'b0);
        send(1'b0, 32'd7, 32'd0, 1'b1, 1'b0);
        send(1'b1, 32'd8, 32'h0000_00FF, 1'b1, 1'b0);
        idle();
        chk("t4_ready_low_full", 32'(req_ready), 0);
        drain("t4_drain");
        chk("t4_ready_back", 32'(req_ready), 1);
        chk("t4_slave_mem8", slave_mem[8], 32'h0000_00FF);

        // Silent slave: timed-out read, then a queued write still completes.
        suppress_valid = 1'b1;
        send(1'b0, 32'd2, 32'd0, 1'b1, 1'b1);
        send(1'b1, 32'd9, 32'hCAFE_0009, 1'b1, 1'b0);
        idle();
        repeat (5) @(posedge clk);
        #1;
        chk("t5_no_early_resp", 32'(resp_valid), 0);
        @(posedge clk); #1;
        chk("t5_timeout_resp", 32'(resp_valid), 1);
        chk("t5_timeout_err", 32'(resp_err), 1);
        drain("t5_drain");
        suppress_valid = 1'b0;
        chk("t5_slave_mem9", slave_mem[9], 32'hCAFE_0009);

        // valid glitches outside RD_WAIT must be ignored.
        glitch_valid = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("t6_idle_glitch", 32'(resp_valid), 0);
        end
        glitch_valid = 1'b0;
        send(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        idle();
        glitch_valid = 1'b1;
        @(posedge clk); #1;
        chk("t6_setup_glitch", 32'(resp_valid), 0);
        @(posedge clk); #1;
        glitch_valid = 1'b0;
        chk("t6_access_glitch", 32'(resp_valid), 0);
        drain("t6_drain");

        // Random traffic against the reference memory.
        for (int k = 0; k < 40; k++) begin
            int gap;
            send(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), $urandom, 1'b1, 1'b0);
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
                idle();
                repeat (gap) @(posedge clk);
                #1;
            end
        end
        idle();
        drain("rand_drain");
        for (int i = 0; i < 16; i++) chk("final_slave_mem", slave_mem[i], mdl_mem[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
